// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings and command decode for the multicycle ARM controller
package mc_pkg;
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_MULEX  = 4'd10;
  localparam logic [3:0] S_MULWB  = 4'd11;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  typedef struct packed {
    logic       ok;
    logic       nowrite;
    logic       cv;
    logic [2:0] op;
  } dec_t;
  // ext selects the 3-bit ALU variant where EOR, MOV and TST exist
  function automatic dec_t decode_cmd(input logic [3:0] cmd, input logic ext);
    dec_t d;
    d = '{ok: 1'b1, nowrite: 1'b0, cv: 1'b0, op: ALU_ADD};
    case (cmd)
      CMD_ADD: d.cv = 1'b1;
      CMD_SUB: begin d.op = ALU_SUB; d.cv = 1'b1; end
      CMD_AND: d.op = ALU_AND;
      CMD_ORR: d.op = ALU_ORR;
      CMD_CMP: begin d.op = ALU_SUB; d.cv = 1'b1; d.nowrite = 1'b1; end
      CMD_TST: begin d.op = ALU_AND; d.nowrite = 1'b1; d.ok = ext; end
      CMD_EOR: begin d.op = ALU_EOR; d.ok = ext; end
      CMD_MOV: begin d.op = ALU_MOV; d.ok = ext; end
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/mc_condlogic.sv
// mc_condlogic: NZCV flag register, condition evaluation and delayed CondEx flop
module mc_condlogic import mc_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       flag_wr_nz_i,
  input  logic       flag_wr_cv_i,
  output logic       cond_ex_o,
  output logic       cond_ex_d_o,
  output logic [3:0] flags_o
);
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_d_q;
  logic       n, z, c, v;
  assign {n, z, c, v} = flags_q;
  assign flags_o      = flags_q;
  assign cond_ex_d_o  = cond_ex_d_q;
  always_comb begin
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = n == v;
      COND_LT: cond_ex_o = n != v;
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end
  always_comb begin
    flags_d = flags_q;
    if (flag_wr_nz_i && cond_ex_o) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_wr_cv_i && cond_ex_o) flags_d[1:0] = alu_flags_i[1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= '0;
      cond_ex_d_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      cond_ex_d_q <= cond_ex_o;
    end
  end
endmodule

// File: rtl/mc_controller_v2.sv
// mc_controller_v2: multicycle ARM control unit with FSM, decoder, MUL sequencing and cond logic
module mc_controller_v2 import mc_pkg::*; #(
  parameter int ALUCTRL_W  = 3,
  parameter int MUL_EN     = 1,
  parameter int MUL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           RegSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 MulStart,
  output logic [3:0]           State
);
  logic [3:0] state_q, state_d, cnt_q, cnt_d;
  logic [1:0] op;
  logic [3:0] rd;
  logic [2:0] alu;
  logic       is_mul, reg_w, mem_w, br, pc_f, fw_nz, fw_cv, cond_ex, cond_ex_d;
  logic       unused_bits;
  dec_t       dec;
  assign op          = Instr[27:26];
  assign dec         = decode_cmd(Instr[24:21], ALUCTRL_W >= 3);
  assign is_mul      = (MUL_EN != 0) && Instr[27:22] == 6'd0 && Instr[7:4] == 4'b1001;
  assign rd          = state_q == S_MULWB ? Instr[19:16] : Instr[15:12];
  assign unused_bits = ^{Instr[11:8], Instr[3:0]};
  assign State       = state_q;
  mc_condlogic u_cond (
    .clk          (clk),
    .rst          (reset),
    .cond_i       (Instr[31:28]),
    .alu_flags_i  (ALUFlags),
    .flag_wr_nz_i (fw_nz),
    .flag_wr_cv_i (fw_cv),
    .cond_ex_o    (cond_ex),
    .cond_ex_d_o  (cond_ex_d),
    .flags_o      ()
  );
  always_comb begin
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = op == 2'b01 ? S_MEMADR :
                          op == 2'b10 ? S_BRANCH :
                          op == 2'b11 ? S_FETCH  :
                          is_mul      ? S_MULEX  :
                          !dec.ok     ? S_FETCH  :
                          Instr[25]   ? S_EXECI  : S_EXECR;
      S_MEMADR: state_d = Instr[20] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = dec.nowrite ? S_FETCH : S_ALUWB;
      S_MULEX:  state_d = cnt_q == 4'(MUL_CYCLES - 1) ? S_MULWB : S_MULEX;
      default:  state_d = S_FETCH;
    endcase
    cnt_d = (state_q == S_MULEX && state_d == S_MULEX) ? cnt_q + 4'd1 : 4'd0;
  end
  always_comb begin
    pc_f = 1'b0; reg_w = 1'b0; mem_w = 1'b0; br = 1'b0;
    IRWrite = 1'b0; AdrSrc = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 2'b00;
    ResultSrc = 2'b00; alu = ALU_ADD; MulStart = 1'b0;
    case (state_q)
      S_FETCH:  begin IRWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; pc_f = 1'b1; end
      S_DECODE: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB:  begin ResultSrc = 2'b01; reg_w = 1'b1; end
      S_MEMWR:  begin AdrSrc = 1'b1; mem_w = 1'b1; end
      S_EXECR:  alu = dec.op;
      S_EXECI:  begin ALUSrcB = 2'b01; alu = dec.op; end
      S_ALUWB:  reg_w = 1'b1;
      S_BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; br = 1'b1; end
      S_MULEX:  MulStart = cnt_q == 4'd0;
      S_MULWB:  begin ResultSrc = 2'b11; reg_w = 1'b1; end
      default:  ;
    endcase
    RegWrite   = reg_w & cond_ex_d;
    MemWrite   = mem_w & cond_ex_d;
    PCWrite    = pc_f | (br & cond_ex_d) | (RegWrite & rd == 4'd15);
    ALUControl = alu[ALUCTRL_W-1:0];
    ImmSrc     = op;
    RegSrc     = {op == 2'b01, op == 2'b10};
    // combinational outputs would otherwise show FETCH strobes while reset holds the FSM
    if (reset) {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ALUControl, MulStart, ImmSrc, RegSrc} = '0;
  end
  assign fw_nz = (state_q == S_EXECR || state_q == S_EXECI) && (Instr[20] || dec.nowrite);
  assign fw_cv = fw_nz && dec.cv;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mc_controller_v2.sv
// tb_mc_controller_v2: scoreboard bench with hand-computed per-cycle control vectors
module tb_mc_controller_v2;
  localparam logic [3:0] F = 0, D = 1, MA = 2, MR = 3, MW = 4, MWR = 5, XR = 6, WB = 8, BR = 9, MX = 10, MB = 11;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, EOR = 3'b100;
  typedef struct packed {
    logic [3:0] st;
    logic       pcw, mw, rw, irw, adr;
    logic [1:0] rs;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] alu;
    logic       ms;
  } out_t;
  typedef struct packed {
    out_t       o;
    logic       fchk;
    logic [3:0] fl;
    logic       chk2;
    logic [3:0] st2;
    logic       rw2;
  } exp_t;
  logic        clk = 0, reset = 1;
  logic [31:0] Instr = 0;
  logic [3:0]  ALUFlags = 0;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, MulStart;
  logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;
  logic        pcw2, mw2, rw2, irw2, adr2, asa2, ms2;
  logic [1:0]  regsrc2, asb2, rs2, imm2, aluc2;
  logic [3:0]  st2;
  exp_t        exp_q[$];
  string       lbl_q[$];
  int          nvec = 0, nerr = 0;
  exp_t        me;
  string       ml;
  out_t        got;
  always #5 clk = ~clk;
  mc_controller_v2 #(.ALUCTRL_W(3), .MUL_EN(1), .MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .MulStart(MulStart), .State(State)
  );
  mc_controller_v2 #(.ALUCTRL_W(2), .MUL_EN(1), .MUL_CYCLES(4)) dut2 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(pcw2), .MemWrite(mw2), .RegWrite(rw2), .IRWrite(irw2),
    .AdrSrc(adr2), .RegSrc(regsrc2), .ALUSrcA(asa2), .ALUSrcB(asb2),
    .ResultSrc(rs2), .ImmSrc(imm2), .ALUControl(aluc2),
    .MulStart(ms2), .State(st2)
  );
  function automatic out_t mk(input logic [3:0] st, input logic [2:0] alu,
                              input logic rw, input logic pcw, input logic mw, input logic ms);
    out_t o;
    o = '0; o.st = st; o.alu = alu; o.rw = rw; o.pcw = pcw; o.mw = mw; o.ms = ms;
    case (st)
      0:    begin o.irw = 1; o.asa = 1; o.asb = 2; o.rs = 2; end
      1:    begin o.asa = 1; o.asb = 2; o.rs = 2; end
      2, 7: o.asb = 1;
      3, 5: o.adr = 1;
      4:    o.rs = 1;
      9:    begin o.asb = 1; o.rs = 2; end
      11:   o.rs = 3;
      default: ;
    endcase
    return o;
  endfunction
  task automatic cyc(input out_t o, input string l, input logic fc, input logic [3:0] fl,
                     input logic c2, input logic [3:0] s2, input logic r2);
    exp_t e;
    e.o = o; e.fchk = fc; e.fl = fl; e.chk2 = c2; e.st2 = s2; e.rw2 = r2;
    exp_q.push_back(e);
    lbl_q.push_back(l);
    @(posedge clk); #1;
  endtask
  task automatic c(input out_t o, input string l);
    cyc(o, l, 0, 4'd0, 0, 4'd0, 0);
  endtask
  task automatic cf(input out_t o, input string l, input logic [3:0] fl);
    cyc(o, l, 1, fl, 0, 4'd0, 0);
  endtask
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      me  = exp_q.pop_front();
      ml  = lbl_q.pop_front();
      got = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, MulStart};
      nvec++;
      if (got !== me.o) begin
        nerr++;
        $display("FAIL %s outputs: got %h want %h", ml, got, me.o);
      end
      if (me.fchk) begin
        nvec++;
        if (dut.u_cond.flags_q !== me.fl) begin
          nerr++;
          $display("FAIL %s flags: got %b want %b", ml, dut.u_cond.flags_q, me.fl);
        end
      end
      if (me.chk2) begin
        nvec++;
        if ({st2, rw2} !== {me.st2, me.rw2}) begin
          nerr++;
          $display("FAIL %s w2 state/regwrite: got %0d/%b want %0d/%b", ml, st2, rw2, me.st2, me.rw2);
        end
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    cf('0, "reset", 4'b0000);
    reset = 0;
    Instr = 32'hE5912004;
    c(mk(F, ADD, 0, 1, 0, 0), "ldr fetch");
    c(mk(D, ADD, 0, 0, 0, 0), "ldr decode");
    c(mk(MA, ADD, 0, 0, 0, 0), "ldr memadr");
    c(mk(MR, ADD, 0, 0, 0, 0), "ldr memrd");
    c(mk(MW, ADD, 1, 0, 0, 0), "ldr memwb");
    Instr = 32'hE5812004;
    c(mk(F, ADD, 0, 1, 0, 0), "str fetch");
    c(mk(D, ADD, 0, 0, 0, 0), "str decode");
    c(mk(MA, ADD, 0, 0, 0, 0), "str memadr");
    c(mk(MWR, ADD, 0, 0, 1, 0), "str memwr");
    Instr = 32'hE0523001; ALUFlags = 4'b0100;
    c(mk(F, ADD, 0, 1, 0, 0), "subs fetch");
    c(mk(D, ADD, 0, 0, 0, 0), "subs decode");
    cf(mk(XR, SUB, 0, 0, 0, 0), "subs execr", 4'b0000);
    cf(mk(WB, ADD, 1, 0, 0, 0), "subs aluwb", 4'b0100);
    Instr = 32'h0A000002;
    c(mk(F, ADD, 0, 1, 0, 0), "beq taken fetch");
    c(mk(D, ADD, 0, 0, 0, 0), "beq taken decode");
    c(mk(BR, ADD, 0, 1, 0, 0), "beq taken branch");
    Instr = 32'hE0923001; ALUFlags = 4'b0000;
    c(mk(F, ADD, 0, 1, 0, 0), "adds fetch");
    c(mk(D, ADD, 0, 0, 0, 0), "adds decode");
    c(mk(XR, ADD, 0, 0, 0, 0), "adds execr");
    cf(mk(WB, ADD, 1, 0, 0, 0), "adds aluwb", 4'b0000);
    Instr = 32'h0A000002;
    c(mk(F, ADD, 0, 1, 0, 0), "beq not-taken fetch");
    c(mk(D, ADD, 0, 0, 0, 0), "beq not-taken decode");
    c(mk(BR, ADD, 0, 0, 0, 0), "beq not-taken branch");
    Instr = 32'hE0030291;
    c(mk(F, ADD, 0, 1, 0, 0), "mul fetch");
    c(mk(D, ADD, 0, 0, 0, 0), "mul decode");
    c(mk(MX, ADD, 0, 0, 0, 1), "mulex 1");
    c(mk(MX, ADD, 0, 0, 0, 0), "mulex 2");
    c(mk(MX, ADD, 0, 0, 0, 0), "mulex 3");
    c(mk(MX, ADD, 0, 0, 0, 0), "mulex 4");
    c(mk(MB, ADD, 1, 0, 0, 0), "mulwb");
    Instr = 32'hE1510002; ALUFlags = 4'b1011;
    c(mk(F, ADD, 0, 1, 0, 0), "cmp fetch");
    c(mk(D, ADD, 0, 0, 0, 0), "cmp decode");
    cf(mk(XR, SUB, 0, 0, 0, 0), "cmp execr", 4'b0000);
    Instr = 32'hE0212003; ALUFlags = 4'b0100;
    cyc(mk(F, ADD, 0, 1, 0, 0), "eor fetch", 1, 4'b1011, 1, F, 0);
    cyc(mk(D, ADD, 0, 0, 0, 0), "eor decode", 0, 4'd0, 1, D, 0);
    cyc(mk(XR, EOR, 0, 0, 0, 0), "eor execr", 0, 4'd0, 1, F, 0);
    cyc(mk(WB, ADD, 1, 0, 0, 0), "eor aluwb", 1, 4'b1011, 1, D, 0);
    Instr = 32'hE5912004;
    c(mk(F, ADD, 0, 1, 0, 0), "abort fetch");
    c(mk(D, ADD, 0, 0, 0, 0), "abort decode");
    c(mk(MA, ADD, 0, 0, 0, 0), "abort memadr");
    reset = 1;
    cf('0, "reset mid-memrd", 4'b0000);
    reset = 0;
    cyc(mk(F, ADD, 0, 1, 0, 0), "post-reset fetch", 1, 4'b0000, 1, F, 0);
    c(mk(D, ADD, 0, 0, 0, 0), "post-reset decode");
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mc_controller_v2.md
Name: mc_controller_v2

Overview:
Parametrised next-generation control unit for the multicycle ARM core. It contains the main FSM, the instruction decoder and the conditional-execution logic with its NZCV flag register. Compared with the first-generation controller it adds:
- a configurable ALUControl width, with EOR/MOV/CMP/TST at 3 bits;
- a counted multi-cycle MUL sequence;
- an undefined-instruction abort path.
It drives the multicycle datapath directly.

Parameters:
ALUCTRL_W, 3, ALUControl width; 2 gives ADD/SUB/AND/ORR only, 3 adds EOR and MOV.
MUL_EN, 1, 1 enables MUL decode and the MULEX/MULWB states.
MUL_CYCLES, 4, number of cycles spent in MULEX (range 1..15).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
Instr  in  32  current instruction (IR output)
ALUFlags  in  4  {N,Z,C,V} from the ALU
PCWrite  out  1  PC register enable
MemWrite  out  1  data memory write
RegWrite  out  1  register file write
IRWrite  out  1  instruction register enable
AdrSrc  out  1  memory address select (0 = PC, 1 = ALUOut)
RegSrc  out  2  register address selects
ALUSrcA  out  1  ALU A select
ALUSrcB  out  2  ALU B select
ResultSrc  out  2  result mux select (00 ALUOut, 01 Data, 10 ALU, 11 MulResult)
ImmSrc  out  2  extend mode
ALUControl  out  ALUCTRL_W  ALU operation
MulStart  out  1  one-cycle start pulse to the external multiplier
State  out  4  current FSM state (debug)

Behaviour:
- Reset: asynchronous, active-high. It clears the FSM to FETCH, Flags to 0000, CondExD to 0 and the MUL counter to 0.
  - While reset is asserted, all strobes (PCWrite, MemWrite, RegWrite, IRWrite, MulStart) read 0; every select reads 0.
  - Reset asserted mid-instruction aborts it; the first state after release is FETCH.
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, MULEX=10, MULWB=11.
- Transitions:
  - FETCH->DECODE.
  - DECODE goes to one of:
    - Op=01: MEMADR.
    - Op=10: BRANCH.
    - Op=00 and I=1: EXECI.
    - Op=00, I=0, MUL pattern (Instr[27:22]=0, Instr[7:4]=1001, MUL_EN=1): MULEX.
    - Op=00, I=0, otherwise: EXECR.
    - Op=11 or an unsupported cmd: FETCH.
  - MEMADR->MEMRD if L=1, else MEMWR. MEMRD->MEMWB.
  - EXECR/EXECI->ALUWB, or ->FETCH if NoWrite (CMP/TST).
  - MULEX holds until its counter reaches MUL_CYCLES-1, then goes to MULWB.
  - MEMWB, MEMWR, ALUWB, BRANCH and MULWB all go to FETCH.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU op ADD, PCWrite=1 unconditionally.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD.
  - MEMADR: ALUSrcB=01, ADD.
  - MEMRD and MEMWR: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite.
  - MEMWR: also MemWrite.
  - EXECR: ALUSrcB=00, decoded op.
  - EXECI: ALUSrcB=01, decoded op.
  - ALUWB: RegWrite.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ADD, PCWrite.
  - MULEX: MulStart=1 in its first cycle only.
  - MULWB: ResultSrc=11, RegWrite.
- Conditional gating:
  - CondEx is evaluated from Instr[31:28] and the registered Flags (all 15 ARM condition codes; 1111 evaluates false).
  - CondExD is registered every cycle.
  - RegWrite, MemWrite and the BRANCH PCWrite are ANDed with CondExD.
  - A register write to Rd=15 also asserts PCWrite, and that PCWrite is gated the same way.
- Flags update at the end of EXECR/EXECI when S=1 (always for CMP/TST) and CondEx=1:
  - N and Z are written for all ops.
  - C and V are written for ADD/SUB/CMP only.
- ALUControl codes: ADD 000, SUB 001, AND 010, ORR 011, EOR 100, MOV 101.
  - ADD, SUB, AND, ORR map to cmd 0100, 0010, 0000, 1100.
  - EOR and MOV map to cmd 0001 and 1101.
  - CMP (1010) uses SUB; TST (1000) uses AND.
  - With ALUCTRL_W=2, EOR, MOV and TST are unsupported: they are aborted at DECODE with no writes and no flag change.
- ImmSrc = Op; RegSrc = {Op==01, Op==10}.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings;
  - ALUControl codes;
  - cmd opcodes;
  - condition-code constants.
- One natural sub-module, mc_condlogic: Flags register, CondEx evaluation and the CondExD flop.
- The FSM and the decoder stay in mc_controller_v2.

Test Plan:
- Reset asserted mid-MEMRD, released -> State=0, IRWrite=1 on the next cycle, Flags=0000.
- LDR E5912004 -> states 0,1,2,3,4; RegWrite=1 only in MEMWB; ResultSrc=01.
- SUBS E0523001 with ALUFlags=0100 -> ALUControl=001 in EXECR; Flags=0100. Next BEQ 0A000002 -> PCWrite=1 in BRANCH. With Flags=0000, PCWrite stays 0.
- MUL E0030291 with MUL_CYCLES=4 -> MULEX held 4 cycles; MulStart high in its first cycle only; MULWB has ResultSrc=11 and RegWrite=1.
- EOR E0212003 with ALUCTRL_W=3 -> ALUControl=100. With ALUCTRL_W=2 -> DECODE->FETCH, no RegWrite.
- CMP E1510002 -> EXECR->FETCH, RegWrite never asserted, Flags updated.
